// File: rtl/key_answer_encoder_if.sv
// key_answer_encoder_if
//   Bundles the key-pad side and the game side of the answer encoder.
//   master : the game/stimulus side (drives btn, busy, clear_count)
//   slave  : the encoder (drives answer, answer_strobe, multi_err, press_count)
//   btn           raw async push-buttons, bit i = note key i
//   busy          melody playback in progress, presses not accepted
//   clear_count   one-cycle request to zero press_count
//   answer        note code 1..8 of the held key, 0 when none accepted
//   answer_strobe one-cycle pulse per accepted press
//   multi_err     one-cycle pulse when a multi-key press is rejected
//   press_count   saturating accepted-press count
interface key_answer_encoder_if;
  logic [7:0] btn;
  logic       busy;
  logic       clear_count;
  logic [3:0] answer;
  logic       answer_strobe;
  logic       multi_err;
  logic [6:0] press_count;

  modport master (
    output btn, busy, clear_count,
    input  answer, answer_strobe, multi_err, press_count
  );

  modport slave (
    input  btn, busy, clear_count,
    output answer, answer_strobe, multi_err, press_count
  );
endinterface

// File: rtl/key_answer_encoder.sv
// key_answer_encoder
//   Debounces eight note keys, converts a single held key into a note code
//   (key i -> i+1), pulses answer_strobe once per accepted press and keeps a
//   saturating count of accepted presses. Multi-key presses are rejected with
//   a multi_err pulse. A key roll-over never produces a second strobe: every
//   key must be released (and the release debounced) before the next press.
// Ports
//   clk    system clock, everything on posedge
//   reset  synchronous, active-high
//   kif    key_answer_encoder_if.slave (btn/busy/clear_count in,
//          answer/answer_strobe/multi_err/press_count out)
// Parameters
//   DEBOUNCE_CYCLES  number of stable samples needed to accept press/release
//                    (must be >= 2)
//   COUNT_W          debounce counter width
module key_answer_encoder #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int COUNT_W         = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  key_answer_encoder_if.slave  kif
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  // The sample that starts debouncing counts as the first stable sample, so
  // the counter "reaches" DEBOUNCE_CYCLES-1 on the edge that takes the last
  // stable sample. This gives press latency 2 (sync) + DEBOUNCE_CYCLES.
  localparam logic [COUNT_W-1:0] CNT_LAST = COUNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0]         CNT_SAT  = 7'd127;

  // ---------------------------------------------------------------------
  // Two-flop synchronizer on the raw buttons
  // ---------------------------------------------------------------------
  logic [7:0] btn_m, btn_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_m <= '0;
      btn_s <= '0;
    end else begin
      btn_m <= kif.btn;
      btn_s <= btn_m;
    end
  end

  // Note code for a one-hot vector; zero and multi-hot give 0 (no code).
  function automatic logic [3:0] note_code(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (v == (8'h01 << i)) c = 4'(i + 1);
    end
    return c;
  endfunction

  // ---------------------------------------------------------------------
  // FSM state and datapath registers
  // ---------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]         cand_q, cand_d;
  logic [3:0]         answer_q, answer_d;
  logic               strobe_q, strobe_d;
  logic               merr_q, merr_d;
  logic [6:0]         count_q;
  logic [3:0]         cand_code;

  assign cnt_inc   = cnt_q + 1'b1;
  assign cand_code = note_code(cand_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      answer_q <= '0;
      strobe_q <= 1'b0;
      merr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      answer_q <= answer_d;
      strobe_q <= strobe_d;
      merr_q   <= merr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    answer_d = answer_q;
    strobe_d = 1'b0;
    merr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // busy only blocks starting a new press
        if (btn_s != 8'h00 && !kif.busy) begin
          cand_d  = btn_s;
          cnt_d   = '0;
          state_d = DB_PRESS;
        end
      end

      DB_PRESS: begin
        if (btn_s == 8'h00) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (btn_s != cand_q) begin
          // pattern still settling: follow it and restart the count
          cand_d = btn_s;
          cnt_d  = '0;
        end else if (cnt_inc == CNT_LAST) begin
          cnt_d = '0;
          if (kif.busy) begin
            // silently rejected; wait for a full release
            state_d = DB_RELEASE;
          end else if (cand_code != 4'd0) begin
            answer_d = cand_code;
            strobe_d = 1'b1;
            state_d  = PRESSED;
          end else begin
            merr_d  = 1'b1;
            state_d = DB_RELEASE;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      PRESSED: begin
        // any change (release or roll-over) goes to release debounce
        if (btn_s != cand_q) begin
          cnt_d   = '0;
          state_d = DB_RELEASE;
        end
      end

      DB_RELEASE: begin
        // answer keeps its value here until the release is accepted
        if (btn_s != 8'h00) begin
          cnt_d = '0;
        end else if (cnt_inc == CNT_LAST) begin
          cnt_d    = '0;
          cand_d   = '0;
          answer_d = 4'd0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        cand_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Press counter: increments with the strobe, clear wins over increment
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (kif.clear_count) begin
      count_q <= '0;
    end else if (strobe_d && count_q != CNT_SAT) begin
      count_q <= count_q + 7'd1;
    end
  end

  assign kif.answer        = answer_q;
  assign kif.answer_strobe = strobe_q;
  assign kif.multi_err     = merr_q;
  assign kif.press_count   = count_q;

endmodule

// File: tb/tb_key_answer_encoder.sv
// tb_key_answer_encoder
//   Directed bench for key_answer_encoder with DEBOUNCE_CYCLES=4. Inputs are
//   driven 1 time unit after posedge; outputs are sampled at the same point,
//   so "tick k" is the state after the k-th posedge following a drive.
//   A clean press shows answer_strobe after tick 6; a clean release clears
//   answer after tick 6.
module tb_key_answer_encoder;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic reset;
  key_answer_encoder_if kif();

  key_answer_encoder #(.DEBOUNCE_CYCLES(DB), .COUNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .kif   (kif)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int n_strb = 0;
  int n_merr = 0;
  int n_both = 0;

  // event monitor, sampled on the opposite edge
  always @(negedge clk) begin
    if (!reset) begin
      if (kif.answer_strobe) n_strb++;
      if (kif.multi_err) n_merr++;
      if (kif.answer_strobe && kif.multi_err) n_both++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] b);
    kif.btn = b;
    repeat (8) tick();
    kif.btn = 8'h00;
    repeat (8) tick();
  endtask

  int s0, m0;

  initial begin
    kif.btn = 8'h00;
    kif.busy = 1'b0;
    kif.clear_count = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    chk("rst_answer", 32'(kif.answer), 0);
    chk("rst_strobe", 32'(kif.answer_strobe), 0);
    chk("rst_merr", 32'(kif.multi_err), 0);
    chk("rst_count", 32'(kif.press_count), 0);
    reset = 1'b0;
    repeat (2) tick();

    // --- clean press of key 2 (8'h04) held 20 cycles ---
    s0 = n_strb;
    kif.btn = 8'h04;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 5) chk("p1_strobe_t5", 32'(kif.answer_strobe), 0);
      if (k == 6) begin
        chk("p1_strobe_t6", 32'(kif.answer_strobe), 1);
        chk("p1_answer_t6", 32'(kif.answer), 3);
      end
      if (k == 7) chk("p1_strobe_t7", 32'(kif.answer_strobe), 0);
    end
    chk("p1_answer_held", 32'(kif.answer), 3);
    kif.btn = 8'h00;
    repeat (5) tick();
    chk("p1_answer_rel5", 32'(kif.answer), 3);
    tick();
    chk("p1_answer_rel6", 32'(kif.answer), 0);
    chk("p1_count", 32'(kif.press_count), 1);
    chk("p1_nstrobe", 32'(n_strb - s0), 1);
    repeat (4) tick();

    // --- bouncing key 0: 2 cycles high, 1 low ---
    s0 = n_strb;
    for (int k = 0; k < 12; k++) begin
      kif.btn = (k % 3 == 2) ? 8'h00 : 8'h01;
      tick();
      chk("bounce_answer", 32'(kif.answer), 0);
    end
    kif.btn = 8'h00;
    repeat (8) tick();
    chk("bounce_nstrobe", 32'(n_strb - s0), 0);

    // --- multi-key press then a valid key 7 ---
    s0 = n_strb; m0 = n_merr;
    kif.btn = 8'h05;
    repeat (6) tick();
    chk("multi_merr_t6", 32'(kif.multi_err), 1);
    repeat (6) tick();
    chk("multi_answer", 32'(kif.answer), 0);
    chk("multi_nmerr", 32'(n_merr - m0), 1);
    chk("multi_nstrobe", 32'(n_strb - s0), 0);
    kif.btn = 8'h00;
    repeat (10) tick();
    kif.btn = 8'h80;
    repeat (6) tick();
    chk("k7_strobe", 32'(kif.answer_strobe), 1);
    chk("k7_answer", 32'(kif.answer), 8);
    kif.btn = 8'h00;
    repeat (10) tick();
    chk("k7_count", 32'(kif.press_count), 2);

    // --- busy at evaluation rejects the press; dropping busy doesn't revive it ---
    s0 = n_strb;
    kif.btn = 8'h02;
    repeat (3) tick();
    kif.busy = 1'b1;
    repeat (7) tick();
    kif.busy = 1'b0;
    repeat (10) tick();
    chk("busy_answer", 32'(kif.answer), 0);
    chk("busy_nstrobe", 32'(n_strb - s0), 0);
    kif.btn = 8'h00;
    repeat (10) tick();
    kif.btn = 8'h02;
    repeat (6) tick();
    chk("busy_repress_strobe", 32'(kif.answer_strobe), 1);
    chk("busy_repress_answer", 32'(kif.answer), 2);
    kif.btn = 8'h00;
    repeat (10) tick();
    chk("busy_count", 32'(kif.press_count), 3);

    // --- saturation and clear ---
    for (int i = 0; i < 130; i++) press(8'h08);
    chk("sat_count", 32'(kif.press_count), 127);
    kif.clear_count = 1'b1;
    tick();
    kif.clear_count = 1'b0;
    chk("clear_count", 32'(kif.press_count), 0);
    press(8'h08);
    chk("after_clear_count", 32'(kif.press_count), 1);

    // clear coincident with strobe -> 0
    kif.btn = 8'h08;
    repeat (5) tick();
    kif.clear_count = 1'b1;
    tick();
    kif.clear_count = 1'b0;
    chk("clr_strobe_strobe", 32'(kif.answer_strobe), 1);
    chk("clr_strobe_count", 32'(kif.press_count), 0);
    kif.btn = 8'h00;
    repeat (10) tick();

    // --- reset while answer=5, key still held afterwards ---
    kif.btn = 8'h10;
    repeat (8) tick();
    chk("r_answer_before", 32'(kif.answer), 5);
    reset = 1'b1;
    tick();
    chk("r_answer_after", 32'(kif.answer), 0);
    chk("r_count_after", 32'(kif.press_count), 0);
    reset = 1'b0;
    repeat (5) tick();
    chk("r_refresh_t5", 32'(kif.answer_strobe), 0);
    tick();
    chk("r_refresh_strobe", 32'(kif.answer_strobe), 1);
    chk("r_refresh_answer", 32'(kif.answer), 5);
    kif.btn = 8'h00;
    repeat (10) tick();

    chk("no_strobe_and_merr", 32'(n_both), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // global time limit
  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
